// File: rtl/mp_pkg.sv
// +----------------------------------------------------------------------------+
// | mp_pkg : shared constants and state type for the memory-side line bus.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mp_pkg;

  localparam int OFFSET_W = 4;
  localparam int SET_W    = 5;
  localparam int TAG_W    = 7;

  localparam int LINE_W   = 128;
  localparam int BUS_W    = 32;
  localparam int BEATS    = LINE_W / BUS_W;
  localparam int STRB_W   = BUS_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_BEAT = 3'd1,
    ST_RD_CMD  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } mp_lb_state_t;

endpackage

`default_nettype wire

// File: rtl/mp_line_bus.sv
// +----------------------------------------------------------------------------+
// | mp_line_bus : splits one 128-bit line read/masked write into four 32-bit   |
// | bus beats, one outstanding at a time. Build option MP_LINE_BUS_SKIP_EN     |
// | suppresses write beats with an all-zero strobe.                            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module mp_line_bus
  import mp_pkg::*;
#(
  parameter int ADDR_W = TAG_W + SET_W + OFFSET_W
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                lb_request,
  input  logic                lb_rwn,
  input  logic [ADDR_W-1:0]   lb_addr,
  input  logic [LINE_W-1:0]   lb_write_data,
  input  logic [LINE_W/8-1:0] lb_write_mask,
  output logic                lb_busy,
  output logic                lb_finish,
  output logic [LINE_W-1:0]   lb_read_data,
  output logic                bus_valid,
  input  logic                bus_ready,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [BUS_W-1:0]    bus_wdata,
  output logic [STRB_W-1:0]   bus_wstrb,
  input  logic                bus_rvalid,
  input  logic [BUS_W-1:0]    bus_rdata
);

  localparam int c_line_aw = ADDR_W - OFFSET_W;
  localparam logic [1:0] c_last_beat = 2'(BEATS - 1);

  mp_lb_state_t          r_state;
  mp_lb_state_t          w_next_state;
  logic [1:0]            r_beat;
  logic [c_line_aw-1:0]  r_line;
  logic [LINE_W-1:0]     r_wdata;
  logic [LINE_W/8-1:0]   r_wmask;
  logic [LINE_W-1:0]     r_read_data;

  logic                  w_start;
  logic                  w_beat_adv;
  logic                  w_rd_capture;
  logic                  w_skip;
  logic [STRB_W-1:0]     w_strb_slice;
  logic [BUS_W-1:0]      w_data_slice;
  logic                  w_unused_offset;

  // Offset bits of the request address are irrelevant: transfers are whole lines.
  assign w_unused_offset = ^lb_addr[OFFSET_W-1:0];

  assign w_start      = (r_state == ST_IDLE) && lb_request;
  assign w_strb_slice = r_wmask[STRB_W*r_beat +: STRB_W];
  assign w_data_slice = r_wdata[BUS_W*r_beat +: BUS_W];

`ifdef MP_LINE_BUS_SKIP_EN
  assign w_skip = (w_strb_slice == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign lb_busy      = (r_state != ST_IDLE);
  assign lb_read_data = r_read_data;
  assign bus_addr     = {r_line, r_beat, {(OFFSET_W-2){1'b0}}};

  always_comb begin
    w_next_state = r_state;
    w_beat_adv   = 1'b0;
    w_rd_capture = 1'b0;
    lb_finish    = 1'b0;
    bus_valid    = 1'b0;
    bus_we       = 1'b0;
    bus_wdata    = '0;
    bus_wstrb    = '0;

    case (r_state)
      ST_IDLE: begin
        if (lb_request) begin
          w_next_state = lb_rwn ? ST_RD_CMD : ST_WR_BEAT;
        end
      end

      ST_WR_BEAT: begin
        bus_we    = 1'b1;
        bus_wdata = w_data_slice;
        bus_wstrb = w_strb_slice;
        bus_valid = !w_skip;
        // A skipped beat still spends its cycle, keeping write latency fixed.
        if (w_skip || bus_ready) begin
          w_beat_adv = 1'b1;
          if (r_beat == c_last_beat) begin
            w_next_state = ST_DONE;
          end
        end
      end

      ST_RD_CMD: begin
        bus_valid = 1'b1;
        if (bus_ready) begin
          w_next_state = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (bus_rvalid) begin
          w_rd_capture = 1'b1;
          w_beat_adv   = 1'b1;
          w_next_state = (r_beat == c_last_beat) ? ST_DONE : ST_RD_CMD;
        end
      end

      ST_DONE: begin
        lb_finish    = 1'b1;
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_beat      <= 2'd0;
      r_line      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_read_data <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_line  <= lb_addr[ADDR_W-1:OFFSET_W];
        r_wdata <= lb_write_data;
        r_wmask <= lb_write_mask;
        r_beat  <= 2'd0;
      end else if (w_beat_adv) begin
        r_beat <= r_beat + 2'd1;
      end
      // Upper beats from an earlier read are deliberately left in place.
      if (w_rd_capture) begin
        r_read_data[BUS_W*r_beat +: BUS_W] <= bus_rdata;
      end
    end
  end

`ifdef MP_LINE_BUS_PROTOCOL_CHECK
  a_no_request_while_busy : assert property (
    @(posedge sys_clk) disable iff (sys_rst) lb_busy |-> !lb_request
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_mp_line_bus.sv
// Self-checking bench for mp_line_bus: a bus responder records accepted beats and
// returns read data; each scenario compares against a line-level reference model.
`default_nettype none

module tb_mp_line_bus;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  logic         clk = 1'b0;
  logic         sys_rst;
  logic         lb_request;
  logic         lb_rwn;
  logic [15:0]  lb_addr;
  logic [127:0] lb_write_data;
  logic [15:0]  lb_write_mask;
  logic         lb_busy;
  logic         lb_finish;
  logic [127:0] lb_read_data;
  logic         bus_valid;
  logic         bus_ready;
  logic         bus_we;
  logic [15:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic [3:0]   bus_wstrb;
  logic         bus_rvalid;
  logic [31:0]  bus_rdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int   ready_mode;
  int   rd_delay;
  int   rd_wait;
  int   stall_used;
  bit   spur_en;
  bit   rd_pattern;
  cmd_t acc_q[$];
  cmd_t stall_obs[$];
  logic [31:0] rd_q[$];
  int   fin_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mp_line_bus #(.ADDR_W(16)) dut (
    .sys_clk      (clk),
    .sys_rst      (sys_rst),
    .lb_request   (lb_request),
    .lb_rwn       (lb_rwn),
    .lb_addr      (lb_addr),
    .lb_write_data(lb_write_data),
    .lb_write_mask(lb_write_mask),
    .lb_busy      (lb_busy),
    .lb_finish    (lb_finish),
    .lb_read_data (lb_read_data),
    .bus_valid    (bus_valid),
    .bus_ready    (bus_ready),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_wstrb    (bus_wstrb),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata)
  );

  // Memory-bus responder and completion monitor, active on the falling edge.
  initial begin : responder
    cmd_t c;
    bus_ready  = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    rd_wait    = 0;
    forever begin
      @(negedge clk);
      if (lb_finish === 1'b1) fin_q.push_back(cyc);
      bus_rvalid = 1'b0;
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          bus_rdata  = rd_pattern ? 32'h11111111 * (rd_q.size() + 1) : $urandom;
          bus_rvalid = 1'b1;
          rd_q.push_back(bus_rdata);
        end
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        bus_rdata  = $urandom;
        bus_rvalid = 1'b1;
      end
      c = '{bus_addr, bus_we, bus_wdata, bus_wstrb};
      case (ready_mode)
        0: bus_ready = 1'b1;
        1: bus_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (bus_valid === 1'b1 && bus_addr[3:2] == 2'd1 && stall_used < 3) begin
            bus_ready = 1'b0;
            stall_used++;
            stall_obs.push_back(c);
          end else begin
            bus_ready = 1'b1;
          end
        end
      endcase
      if (bus_valid === 1'b1 && bus_ready && !sys_rst) begin
        acc_q.push_back(c);
        if (!bus_we) rd_wait = rd_delay;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input bit rwn, input logic [15:0] addr, input logic [127:0] data,
                       input logic [15:0] mask, output int req_cyc);
    int n = 0;
    while (lb_busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    lb_request    = 1'b1;
    lb_rwn        = rwn;
    lb_addr       = addr;
    lb_write_data = data;
    lb_write_mask = mask;
    req_cyc       = cyc;
    step();
    lb_request = 1'b0;
  endtask

  // One full transfer checked against the line-level model; exp_lat < 0 skips timing.
  task automatic run_xfer(input string name, input bit rwn, input logic [15:0] addr,
                          input logic [127:0] data, input logic [15:0] mask, input int exp_lat);
    int req_cyc;
    int n;
    bit skip;
    cmd_t e;
    cmd_t exp_q[$];
    logic [127:0] exp_line;
    acc_q.delete();
    rd_q.delete();
    fin_q.delete();
    issue(rwn, addr, data, mask, req_cyc);
    n = 0;
    while (fin_q.size() == 0 && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (fin_q.size() == 0) begin
      errors++;
      $display("FAIL %s finish: got no lb_finish within 400 cycles, required one", name);
      return;
    end
    if (exp_lat >= 0) begin
      checks++;
      if (fin_q[0] - req_cyc !== exp_lat) begin
        errors++;
        $display("FAIL %s latency: got T+%0d required T+%0d", name, fin_q[0] - req_cyc, exp_lat);
      end
    end
    step();
    step();
    checks++;
    if (fin_q.size() !== 1) begin
      errors++;
      $display("FAIL %s finish_count: got %0d pulses required 1", name, fin_q.size());
    end

    for (int b = 0; b < 4; b++) begin
      e.addr  = {addr[15:4], 2'(b), 2'b00};
      e.we    = !rwn;
      e.wdata = rwn ? 32'h0 : data[32*b +: 32];
      e.wstrb = rwn ? 4'h0 : mask[4*b +: 4];
      skip = 1'b0;
`ifdef MP_LINE_BUS_SKIP_EN
      skip = !rwn && (e.wstrb == 4'h0);
`endif
      if (!skip) exp_q.push_back(e);
    end
    checks++;
    if (acc_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s cmd_count: got %0d commands required %0d", name, acc_q.size(), exp_q.size());
    end
    for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (acc_q[i].addr !== exp_q[i].addr || acc_q[i].we !== exp_q[i].we ||
          acc_q[i].wstrb !== exp_q[i].wstrb || (!rwn && acc_q[i].wdata !== exp_q[i].wdata)) begin
        errors++;
        $display("FAIL %s cmd%0d: got addr=%h we=%b wdata=%h wstrb=%h required addr=%h we=%b wdata=%h wstrb=%h",
                 name, i, acc_q[i].addr, acc_q[i].we, acc_q[i].wdata, acc_q[i].wstrb,
                 exp_q[i].addr, exp_q[i].we, exp_q[i].wdata, exp_q[i].wstrb);
      end
    end
    if (rwn) begin
      exp_line = 'x;
      if (rd_q.size() == 4) exp_line = {rd_q[3], rd_q[2], rd_q[1], rd_q[0]};
      checks++;
      if (rd_q.size() != 4 || lb_read_data !== exp_line) begin
        errors++;
        $display("FAIL %s read_data: got %h required %h (%0d beats delivered)",
                 name, lb_read_data, exp_line, rd_q.size());
      end
    end
  endtask

  task automatic test_reset();
    sys_rst    = 1'b1;
    lb_request = 1'b1;
    lb_rwn     = 1'b0;
    repeat (3) step();
    checks++;
    if ({lb_busy, lb_finish, bus_valid, bus_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/finish/valid/we=%b required 0000",
               {lb_busy, lb_finish, bus_valid, bus_we});
    end
    checks++;
    if (bus_addr !== 16'h0 || bus_wdata !== 32'h0 || bus_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%h required all zero",
               bus_addr, bus_wdata, bus_wstrb);
    end
    checks++;
    if (lb_read_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h required 0", lb_read_data);
    end
    sys_rst    = 1'b0;
    lb_request = 1'b0;
    step();
  endtask

  task automatic test_write_basic();
    ready_mode = 0;
    run_xfer("wr_basic", 1'b0, 16'h1230, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, 5);
  endtask

  task automatic test_read_basic();
    ready_mode = 0;
    rd_delay   = 1;
    rd_pattern = 1'b1;
    run_xfer("rd_basic", 1'b1, 16'hA5C7, 128'h0, 16'h0, 9);
    rd_pattern = 1'b0;
    checks++;
    if (lb_read_data !== 128'h44444444_33333333_22222222_11111111) begin
      errors++;
      $display("FAIL rd_basic_const: got %h required 44444444333333332222222211111111", lb_read_data);
    end
  endtask

  task automatic test_stall();
    logic [127:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    ready_mode = 2;
    stall_used = 0;
    stall_obs.delete();
    run_xfer("wr_stall", 1'b0, 16'h4C80, d, 16'hFFFF, 8);
    checks++;
    if (stall_obs.size() !== 3) begin
      errors++;
      $display("FAIL wr_stall_cycles: got %0d stalled cycles required 3", stall_obs.size());
    end
    for (int i = 0; i < stall_obs.size(); i++) begin
      checks++;
      if (stall_obs[i].addr !== 16'h4C84 || stall_obs[i].wdata !== d[63:32] || stall_obs[i].wstrb !== 4'hF) begin
        errors++;
        $display("FAIL wr_stall_hold%0d: got addr=%h wdata=%h wstrb=%h required addr=4c84 wdata=%h wstrb=f",
                 i, stall_obs[i].addr, stall_obs[i].wdata, stall_obs[i].wstrb, d[63:32]);
      end
    end
    ready_mode = 0;
  endtask

  task automatic test_skip();
    ready_mode = 0;
    run_xfer("wr_mask_f00f", 1'b0, 16'h0770, {$urandom, $urandom, $urandom, $urandom}, 16'hF00F, 5);
    run_xfer("wr_mask_zero", 1'b0, 16'hFFF0, {$urandom, $urandom, $urandom, $urandom}, 16'h0000, 5);
  endtask

  task automatic test_reset_mid();
    int req_cyc;
    int n = 0;
    ready_mode = 0;
    rd_delay   = 3;
    acc_q.delete();
    issue(1'b1, 16'h3A50, 128'h0, 16'h0, req_cyc);
    while (acc_q.size() < 2 && n < 100) begin
      step();
      n++;
    end
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    checks++;
    if (lb_busy !== 1'b0 || bus_valid !== 1'b0 || lb_read_data !== 128'h0) begin
      errors++;
      $display("FAIL rst_mid: got busy=%b valid=%b rdata=%h required 0 0 0", lb_busy, bus_valid, lb_read_data);
    end
    repeat (3) step();
    checks++;
    if (lb_busy !== 1'b0 || lb_read_data !== 128'h0) begin
      errors++;
      $display("FAIL rst_late_rvalid: got busy=%b rdata=%h required 0 0", lb_busy, lb_read_data);
    end
    rd_delay = 1;
    run_xfer("rd_after_rst", 1'b1, 16'h3A50, 128'h0, 16'h0, 9);
  endtask

  task automatic test_held_request();
    int c;
    int free_at;
    int exp_fin[$];
    ready_mode = 0;
    fin_q.delete();
    acc_q.delete();
    lb_request    = 1'b1;
    lb_rwn        = 1'b0;
    lb_addr       = 16'h5550;
    lb_write_data = {$urandom, $urandom, $urandom, $urandom};
    lb_write_mask = 16'hFFFF;
    c = cyc;
    repeat (13) step();
    lb_request = 1'b0;
    repeat (20) step();
    free_at = c;
    for (int t = c; t <= c + 12; t++) begin
      if (t >= free_at) begin
        exp_fin.push_back(t + 5);
        free_at = t + 6;
      end
    end
    checks++;
    if (fin_q.size() !== exp_fin.size() || acc_q.size() !== 4 * exp_fin.size()) begin
      errors++;
      $display("FAIL held_req_count: got %0d finishes %0d commands required %0d finishes %0d commands",
               fin_q.size(), acc_q.size(), exp_fin.size(), 4 * exp_fin.size());
    end
    for (int i = 0; i < fin_q.size() && i < exp_fin.size(); i++) begin
      checks++;
      if (fin_q[i] - c !== exp_fin[i] - c) begin
        errors++;
        $display("FAIL held_req_fin%0d: got T+%0d required T+%0d", i, fin_q[i] - c, exp_fin[i] - c);
      end
    end
  endtask

  task automatic test_random();
    bit          rwn;
    logic [15:0] mask;
    int          lat;
    for (int i = 0; i < 20; i++) begin
      rwn        = $urandom_range(0, 1);
      ready_mode = $urandom_range(0, 1);
      rd_delay   = $urandom_range(1, 3);
      spur_en    = $urandom_range(0, 1);
      for (int b = 0; b < 4; b++) mask[4*b +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      lat = (ready_mode != 0) ? -1 : (rwn ? 4 * (1 + rd_delay) + 1 : 5);
      run_xfer($sformatf("rand%0d", i), rwn, 16'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, mask, lat);
    end
    spur_en    = 1'b0;
    ready_mode = 0;
  endtask

  initial begin : main
    sys_rst       = 1'b1;
    lb_request    = 1'b0;
    lb_rwn        = 1'b0;
    lb_addr       = '0;
    lb_write_data = '0;
    lb_write_mask = '0;
    ready_mode    = 0;
    rd_delay      = 1;
    stall_used    = 0;
    spur_en       = 1'b0;
    rd_pattern    = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_stall();
    test_skip();
    test_reset_mid();
    test_held_request();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mp_line_bus.md
Name: mp_line_bus

Overview:
- Memory-side line transfer stage, directly downstream of the victim/line-filler buffer.
- Converts one 128-bit cache-line read or masked write into four 32-bit beats on the external memory bus, one beat outstanding at a time.
- Returns the assembled line on reads.
- Address layout (16-bit byte address): tag[15:9], set[8:4], offset[3:0]; a line is 16 bytes.

Parameters:
- ADDR_W, 16, byte address width.
- LINE_W, 128, line width in bits.
- BUS_W, 32, bus beat width; BEATS = LINE_W/BUS_W = 4, STRB_W = BUS_W/8 = 4.

Ports:
- sys_clk  in  1  clock; all logic rising-edge.
- sys_rst  in  1  synchronous active-high reset.
- lb_request  in  1  line transfer request, single-cycle qualifier, sampled only while idle.
- lb_rwn  in  1  1 = read line, 0 = write line.
- lb_addr  in  ADDR_W  line byte address; bits [3:0] ignored.
- lb_write_data  in  LINE_W  write line, byte 0 at bits [7:0].
- lb_write_mask  in  LINE_W/8  per-byte write enable.
- lb_busy  out  1  transfer in progress; lb_request must be low while high.
- lb_finish  out  1  one-cycle completion pulse.
- lb_read_data  out  LINE_W  assembled read line.
- bus_valid  out  1  beat command valid.
- bus_ready  in  1  beat command accepted when valid&&ready.
- bus_we  out  1  beat is write.
- bus_addr  out  ADDR_W  beat byte address {line[ADDR_W-1:4], beat[1:0], 2'b00}.
- bus_wdata  out  BUS_W  write beat data.
- bus_wstrb  out  STRB_W  write beat byte strobes.
- bus_rvalid  in  1  read beat data valid.
- bus_rdata  in  BUS_W  read beat data.

Behaviour:
- Reset: state IDLE, beat counter 0, lb_busy 0, lb_finish 0, bus_valid 0, bus_we 0, bus_addr 0, bus_wdata 0, bus_wstrb 0, lb_read_data 0.
- States: IDLE, WR_BEAT, RD_CMD, RD_WAIT, DONE.
- IDLE:
  - On lb_request, latch addr[15:4], rwn, data and mask at edge T; beat = 0; lb_busy = 1 from T+1.
  - Next state is WR_BEAT or RD_CMD.
- WR_BEAT:
  - bus_valid = 1, bus_we = 1, bus_wdata = data[32*beat +: 32], bus_wstrb = mask[4*beat +: 4].
  - Outputs are held stable until accepted.
  - On acceptance, beat++; after beat 3 is accepted, go to DONE.
- RD_CMD:
  - bus_valid = 1, bus_we = 0, bus_wstrb = 0.
  - On acceptance, go to RD_WAIT with bus_valid = 0.
- RD_WAIT:
  - On bus_rvalid, write bus_rdata into lb_read_data[32*beat +: 32] and beat++.
  - If beat was 3, go to DONE; otherwise go to RD_CMD.
- DONE:
  - lb_finish = 1 for exactly one cycle; lb_busy still 1. Next state is IDLE.
  - lb_read_data is valid in the DONE cycle and holds until the next read starts overwriting it.
  - The stale upper beats of lb_read_data are not cleared.
- Latency with bus_ready = 1:
  - Write: lb_finish at T+5.
  - Read with bus_rvalid one cycle after acceptance: lb_finish at T+9.
- Boundaries:
  - bus_ready low stalls indefinitely without changing outputs.
  - bus_rvalid outside RD_WAIT is ignored.
  - lb_request while lb_busy is ignored (protocol violation; simulation assertion).
  - lb_request in the DONE cycle is ignored.
  - Beat counter is 2 bits and wraps 3 to 0 only on exit.
- Reset mid-transfer: returns to IDLE at the next edge; bus_valid drops; any pending read beat is discarded. The external bus must be reset together with this block.

Optional Feature:
- Macro MP_LINE_BUS_SKIP_EN.
- Defined: a write beat whose 4-bit strobe slice is 0 issues no bus command. In WR_BEAT, bus_valid stays 0 for one cycle and beat advances. Total write latency is unchanged (T+5 with bus_ready = 1), and an all-zero mask produces zero bus commands.
- Undefined: all four write beats are always issued, including those with bus_wstrb = 0.
- Reads are unaffected either way.

Decomposition:
- Shared package mp_pkg:
  - Address field constants OFFSET_W = 4, SET_W = 5, TAG_W = 7.
  - LINE_W, BUS_W, BEATS.
  - State enum mp_lb_state_t.
- No sub-module; beat mux/demux is inline.

Test Plan:
- Write addr 0x1230, data 0x0F0E..00 pattern, mask 0xFFFF, bus_ready = 1 → addresses 0x1230/34/38/3C, wstrb 0xF each, lb_finish at T+5.
- Read addr 0xA5C7, rdata beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 with rvalid one cycle after acceptance → addresses 0xA5C0..0xA5CC, lb_read_data = 0x44444444_33333333_22222222_11111111, finish at T+9.
- Write with bus_ready low for 3 cycles on beat 1 → bus_addr, bus_wdata and bus_wstrb are held; finish at T+8.
- Write mask 0xF00F with SKIP_EN defined → only beats 0 and 3 appear on the bus; finish at T+5. With SKIP_EN undefined → 4 beats, wstrb 0xF, 0x0, 0x0, 0xF.
- sys_rst asserted in RD_WAIT after beat 1 → next cycle lb_busy = 0, bus_valid = 0; a late bus_rvalid is ignored; a new request completes normally.
- lb_request held high through busy and DONE → exactly one transfer per idle sample, no spurious second lb_finish.
